// File: rtl/i2s_rx_deserializer.sv
// I2S / left-justified serial receiver: deserializes alternating left/right slots into parallel words.
// Optional sticky short-slot flag: define I2S_RX_FRAME_ERR_EN to enable frame_err.
module i2s_rx_deserializer #(
    parameter int WORD_LENGTH = 16,
    parameter int DATA_DELAY  = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   lrck,
    input  logic                   sdata,
    output logic [WORD_LENGTH-1:0] data_l,
    output logic [WORD_LENGTH-1:0] data_r,
    output logic                   valid_l,
    output logic                   valid_r,
    output logic                   frame_err
);

    localparam int                 CNT_W    = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;
    localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(WORD_LENGTH - 1);

    typedef enum logic [1:0] {IDLE, SKIP, SHIFT, HOLD} state_t;

    state_t                 r_state;
    logic                   r_lrck_q;
    logic                   r_chan;
    logic [WORD_LENGTH-1:0] r_shift;
    logic [CNT_W-1:0]       r_cnt;
    logic [WORD_LENGTH-1:0] r_data_l;
    logic [WORD_LENGTH-1:0] r_data_r;
    logic                   r_valid_l;
    logic                   r_valid_r;

    logic                   w_edge;
    logic [WORD_LENGTH-1:0] w_word;

    assign w_edge = lrck ^ r_lrck_q;
    assign w_word = {r_shift[WORD_LENGTH-2:0], sdata};

    // NOTE: all state is updated with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_lrck_q  <= 1'b0;
            r_chan    <= 1'b0;
            r_shift   <= '0;
            r_cnt     <= '0;
            r_data_l  <= '0;
            r_data_r  <= '0;
            r_valid_l <= 1'b0;
            r_valid_r <= 1'b0;
        end else begin
            r_lrck_q  <= lrck;
            // NOTE: valids default low each cycle, so a load below yields exactly a one-cycle pulse.
            r_valid_l <= 1'b0;
            r_valid_r <= 1'b0;
            if (w_edge) begin
                // An edge always starts a new slot; any partial word in progress is dropped.
                r_chan <= lrck;
                if (DATA_DELAY == 1) begin
                    r_state <= SKIP;
                    r_shift <= '0;
                    r_cnt   <= '0;
                end else begin
                    r_state <= SHIFT;
                    r_shift <= WORD_LENGTH'(sdata);
                    r_cnt   <= CNT_W'(1);
                end
            end else begin
                case (r_state)
                    SKIP, SHIFT: begin
                        r_shift <= w_word;
                        if (r_cnt == LAST_BIT) begin
                            r_state <= HOLD;
                            r_cnt   <= '0;
                            if (r_chan) begin
                                r_data_r  <= w_word;
                                r_valid_r <= 1'b1;
                            end else begin
                                r_data_l  <= w_word;
                                r_valid_l <= 1'b1;
                            end
                        end else begin
                            r_state <= SHIFT;
                            r_cnt   <= r_cnt + CNT_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef I2S_RX_FRAME_ERR_EN
    logic r_frame_err;

    // A slot cut short by an lrck edge before its last bit was taken latches the error.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_frame_err <= 1'b0;
        end else if (w_edge && ((r_state == SKIP) || (r_state == SHIFT))) begin
            r_frame_err <= 1'b1;
        end
    end

    assign frame_err = r_frame_err;
`else
    assign frame_err = 1'b0;
`endif

    assign data_l  = r_data_l;
    assign data_r  = r_data_r;
    assign valid_l = r_valid_l;
    assign valid_r = r_valid_r;

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// Directed bench for i2s_rx_deserializer: slot-level model builds expected outputs per cycle
// for a DATA_DELAY=1 instance and a DATA_DELAY=0 instance.
module tb_i2s_rx_deserializer;

    localparam int WL = 16;
    localparam int N  = 1024;
`ifdef I2S_RX_FRAME_ERR_EN
    localparam bit FE_EN = 1'b1;
`else
    localparam bit FE_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b0;
    logic lrck  = 1'b0;
    logic sdata = 1'b0;

    logic [WL-1:0] d1_l, d1_r, d0_l, d0_r;
    logic          v1_l, v1_r, f1, v0_l, v0_r, f0;

    i2s_rx_deserializer #(.WORD_LENGTH(WL), .DATA_DELAY(1)) u_dut_dd1 (
        .clk(clk), .reset(reset), .lrck(lrck), .sdata(sdata),
        .data_l(d1_l), .data_r(d1_r), .valid_l(v1_l), .valid_r(v1_r), .frame_err(f1)
    );

    i2s_rx_deserializer #(.WORD_LENGTH(WL), .DATA_DELAY(0)) u_dut_dd0 (
        .clk(clk), .reset(reset), .lrck(lrck), .sdata(sdata),
        .data_l(d0_l), .data_r(d0_r), .valid_l(v0_l), .valid_r(v0_r), .frame_err(f0)
    );

    // Stimulus per cycle, slot events, and expected outputs after the rising edge of each cycle.
    bit            st_rst [N];
    bit            st_lrck[N];
    bit            st_sd  [N];
    bit            ev_vl  [N];
    bit            ev_vr  [N];
    bit            ev_fe  [N];
    logic [WL-1:0] ev_w   [N];
    logic [WL-1:0] x_dl   [N];
    logic [WL-1:0] x_dr   [N];
    bit            x_vl   [N];
    bit            x_vr   [N];
    bit            x_fe   [N];

    int            lit_idx [$];
    int            lit_kind[$];
    logic [WL-1:0] lit_val [$];

    int n_cyc;
    int dd;
    bit prev_lrck;
    bit pend_short;
    int n_vec = 0;
    int n_err = 0;

    task automatic clear_build(input int delay);
        dd         = delay;
        n_cyc      = 0;
        prev_lrck  = 1'b0;
        pend_short = 1'b0;
        lit_idx.delete();
        lit_kind.delete();
        lit_val.delete();
        for (int i = 0; i < N; i++) begin
            st_rst[i] = 1'b0; st_lrck[i] = 1'b0; st_sd[i] = 1'b0;
            ev_vl[i] = 1'b0; ev_vr[i] = 1'b0; ev_fe[i] = 1'b0; ev_w[i] = '0;
        end
    endtask

    task automatic room(input int len);
        if (n_cyc + len > N) begin
            $display("FAIL stimulus_overflow: need %0d cycles, have %0d", n_cyc + len, N);
            $fatal(1);
        end
    endtask

    task automatic add_reset(input int len);
        room(len);
        for (int k = 0; k < len; k++) begin
            st_rst[n_cyc] = 1'b0; st_lrck[n_cyc] = 1'b0; st_sd[n_cyc] = 1'b0;
            n_cyc++;
        end
        prev_lrck  = 1'b0;
        pend_short = 1'b0;
    endtask

    task automatic add_fill(input int len);
        room(len);
        for (int k = 0; k < len; k++) begin
            st_rst[n_cyc] = 1'b1; st_lrck[n_cyc] = prev_lrck;
            st_sd[n_cyc]  = 1'($urandom_range(0, 1));
            n_cyc++;
        end
    endtask

    // A slot of len clocks starting with an lrck edge; accepted only if the next edge comes after the last bit.
    task automatic add_slot(input bit ch, input int len, input logic [WL-1:0] w, output int e);
        int idx;
        room(len);
        e = n_cyc;
        if (pend_short) ev_fe[e] = 1'b1;
        pend_short = (len < dd + WL);
        for (int k = 0; k < len; k++) begin
            idx = k - dd;
            st_rst[e+k]  = 1'b1;
            st_lrck[e+k] = ch;
            if (idx >= 0 && idx < WL) st_sd[e+k] = w[WL-1-idx];
            else                      st_sd[e+k] = 1'($urandom_range(0, 1));
        end
        if (!pend_short) begin
            if (ch) ev_vr[e+dd+WL-1] = 1'b1;
            else    ev_vl[e+dd+WL-1] = 1'b1;
            ev_w[e+dd+WL-1] = w;
        end
        prev_lrck = ch;
        n_cyc += len;
    endtask

    task automatic pin(input int idx, input int kind, input logic [WL-1:0] val);
        lit_idx.push_back(idx);
        lit_kind.push_back(kind);
        lit_val.push_back(val);
    endtask

    task automatic sweep();
        logic [WL-1:0] el, er;
        bit            fe;
        el = '0; er = '0; fe = 1'b0;
        for (int c = 0; c < n_cyc; c++) begin
            x_vl[c] = 1'b0; x_vr[c] = 1'b0;
            if (!st_rst[c]) begin
                el = '0; er = '0; fe = 1'b0;
            end else begin
                if (ev_vl[c]) begin el = ev_w[c]; x_vl[c] = 1'b1; end
                if (ev_vr[c]) begin er = ev_w[c]; x_vr[c] = 1'b1; end
                if (ev_fe[c] && FE_EN) fe = 1'b1;
            end
            x_dl[c] = el; x_dr[c] = er; x_fe[c] = fe;
        end
    endtask

    function automatic logic [WL-1:0] pick(input int kind, input logic [WL-1:0] dl, input logic [WL-1:0] dr,
                                           input logic vl, input logic vr, input logic fe);
        case (kind)
            0:       return dl;
            1:       return dr;
            2:       return WL'(vl);
            3:       return WL'(vr);
            default: return WL'(fe);
        endcase
    endfunction

    task automatic chk(input string name, input int c, input logic [WL-1:0] act, input logic [WL-1:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d (dd=%0d): got %h expected %h", name, c, dd, act, exp);
        end
    endtask

    task automatic compare(input int c, input bit sel);
        logic [WL-1:0] a_dl, a_dr;
        logic          a_vl, a_vr, a_fe;
        a_dl = sel ? d1_l : d0_l;
        a_dr = sel ? d1_r : d0_r;
        a_vl = sel ? v1_l : v0_l;
        a_vr = sel ? v1_r : v0_r;
        a_fe = sel ? f1   : f0;
        n_vec++;
        chk("data_l",    c, a_dl,     x_dl[c]);
        chk("data_r",    c, a_dr,     x_dr[c]);
        chk("valid_l",   c, WL'(a_vl), WL'(x_vl[c]));
        chk("valid_r",   c, WL'(a_vr), WL'(x_vr[c]));
        chk("frame_err", c, WL'(a_fe), WL'(x_fe[c]));
        chk("valid_both", c, WL'(a_vl & a_vr), '0);
        for (int i = 0; i < lit_idx.size(); i++) begin
            if (lit_idx[i] == c) begin
                chk($sformatf("pin_dut_k%0d", lit_kind[i]), c,
                    pick(lit_kind[i], a_dl, a_dr, a_vl, a_vr, a_fe), lit_val[i]);
                chk($sformatf("pin_model_k%0d", lit_kind[i]), c,
                    pick(lit_kind[i], x_dl[c], x_dr[c], x_vl[c], x_vr[c], x_fe[c]), lit_val[i]);
            end
        end
    endtask

    task automatic run(input bit sel);
        for (int c = 0; c < n_cyc; c++) begin
            @(negedge clk);
            if (c > 0) compare(c - 1, sel);
            reset = st_rst[c];
            lrck  = st_lrck[c];
            sdata = st_sd[c];
        end
        @(negedge clk);
        compare(n_cyc - 1, sel);
    endtask

    initial begin
        int e, e2, r;

        // DATA_DELAY = 1
        clear_build(1);
        add_reset(4);
        pin(3, 0, 16'h0000); pin(3, 1, 16'h0000); pin(3, 2, 16'h0000);
        add_fill(9);
        pin(n_cyc - 1, 2, 16'h0000); pin(n_cyc - 1, 3, 16'h0000);
        add_slot(1'b1, 32, 16'h5555, e);
        pin(e + 16, 3, 16'h0001); pin(e + 16, 1, 16'h5555);
        add_slot(1'b0, 32, 16'hA5C3, e);
        pin(e + 15, 2, 16'h0000); pin(e + 16, 2, 16'h0001); pin(e + 16, 0, 16'hA5C3);
        pin(e + 17, 2, 16'h0000);
        add_slot(1'b1, 32, 16'h0F0F, e);
        pin(e + 16, 3, 16'h0001); pin(e + 16, 1, 16'h0F0F);
        add_slot(1'b0, 32, 16'h1111, e);
        add_slot(1'b1, 32, 16'h1234, e);
        pin(e + 16, 1, 16'h1234);
        add_slot(1'b0, 32, 16'h2222, e);
        add_slot(1'b1, 10, 16'hFFFF, e2);
        add_slot(1'b0, 32, 16'h3333, e);
        pin(e, 4, 16'(FE_EN)); pin(e, 1, 16'h1234); pin(e, 3, 16'h0000);
        add_slot(1'b1, 32, 16'h4321, e);
        pin(e + 16, 3, 16'h0001); pin(e + 16, 1, 16'h4321);
        add_slot(1'b0, 17, 16'h6789, e);
        pin(e + 16, 2, 16'h0001); pin(e + 16, 0, 16'h6789);
        add_slot(1'b1, 16, 16'hABCD, e);
        pin(e + 15, 3, 16'h0000); pin(e + 16, 3, 16'h0000); pin(e + 16, 1, 16'h4321);
        add_slot(1'b0, 32, 16'h7E81, e);
        add_slot(1'b1, 32, 16'hBEEF, e);
        add_slot(1'b0, 8, 16'h9999, e);
        r = n_cyc;
        add_reset(2);
        pin(r, 0, 16'h0000); pin(r, 1, 16'h0000); pin(r, 2, 16'h0000); pin(r, 4, 16'h0000);
        add_fill(6);
        add_slot(1'b1, 32, 16'h0FF1, e);
        pin(e + 16, 3, 16'h0001); pin(e + 16, 1, 16'h0FF1); pin(e + 16, 0, 16'h0000);
        add_slot(1'b0, 32, 16'h1357, e);
        pin(e + 16, 0, 16'h1357);
        add_slot(1'b1, 40, 16'h2468, e);
        sweep();
        run(1'b1);

        // DATA_DELAY = 0
        clear_build(0);
        add_reset(3);
        add_fill(5);
        add_slot(1'b1, 32, 16'h0AAA, e);
        add_slot(1'b0, 32, 16'h8001, e);
        pin(e + 14, 2, 16'h0000); pin(e + 15, 2, 16'h0001); pin(e + 15, 0, 16'h8001);
        add_slot(1'b1, 16, 16'h7777, e);
        pin(e + 15, 3, 16'h0001); pin(e + 15, 1, 16'h7777);
        add_slot(1'b0, 15, 16'hFFFF, e);
        add_slot(1'b1, 40, 16'h5A5A, e);
        pin(e, 0, 16'h8001); pin(e, 4, 16'(FE_EN)); pin(e + 15, 1, 16'h5A5A);
        sweep();
        run(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/i2s_rx_deserializer.md
I2S_RX_DESERIALIZER -- requirements
Module: i2s_rx_deserializer

Interface
REQ-001 SHALL have parameter WORD_LENGTH, default 16: sample width in bits, MSB first.
REQ-002 SHALL have parameter DATA_DELAY, default 1: bit slots skipped after each lrck edge (1 = I2S, 0 = left-justified); legal values are 0 and 1.
REQ-003 SHALL have port clk, input, 1 bit: bit clock; all logic is on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port lrck, input, 1 bit: channel select (0 = left, 1 = right).
REQ-006 SHALL have port sdata, input, 1 bit: serial ADC data.
REQ-007 SHALL have port data_l, output, WORD_LENGTH bits: last complete left word.
REQ-008 SHALL have port data_r, output, WORD_LENGTH bits: last complete right word.
REQ-009 SHALL have port valid_l, output, 1 bit: one-cycle pulse when data_l updates.
REQ-010 SHALL have port valid_r, output, 1 bit: one-cycle pulse when data_r updates.
REQ-011 SHALL have port frame_err, output, 1 bit: sticky short-slot error flag (see Configuration).

Function
REQ-012 SHALL register lrck every cycle into lrck_q; an edge is detected in cycle E when lrck != lrck_q.
REQ-013 SHALL latch the slot channel as the value of lrck in cycle E.
REQ-014 SHALL implement states IDLE, SKIP, SHIFT and HOLD.
REQ-015 SHALL leave IDLE only on the first detected edge, discarding the partial frame that was in progress at reset release.
REQ-016 SHALL, on an edge, go to SKIP if DATA_DELAY=1 (ignoring sdata in cycle E), or go to SHIFT with sdata of cycle E taken as the MSB if DATA_DELAY=0.
REQ-017 SHALL, in SHIFT, shift sdata into an internal shift register MSB first, with a bit counter running 0..WORD_LENGTH-1.
REQ-018 SHALL go to HOLD after the bit captured at counter = WORD_LENGTH-1.
REQ-019 SHALL sample the last bit in cycle E+DATA_DELAY+WORD_LENGTH-1.
REQ-020 SHALL, on the transition into HOLD, load the full word into data_l or data_r per the latched channel and assert the matching valid for exactly one cycle, in cycle E+DATA_DELAY+WORD_LENGTH.
REQ-021 SHALL ignore sdata bits after the last captured bit while in HOLD, so slots longer than the word are allowed.
REQ-022 SHALL, for an edge detected in HOLD, start the next slot per REQ-016.
REQ-023 SHALL give an edge detected in SKIP or SHIFT (short slot) priority: the partial word is discarded, no valid pulse is issued, the data outputs are unchanged, and a new slot starts per REQ-016.
REQ-024 SHALL apply REQ-023 to an edge in the same cycle as the last-bit capture: that is a short slot.
REQ-025 SHALL never assert valid_l and valid_r in the same cycle.
REQ-026 SHALL hold data_l and data_r stable between their valid pulses.
REQ-027 SHALL keep the data outputs raw two's-complement bit patterns; no sign extension or arithmetic.

Reset
REQ-028 SHALL, when reset=0 at a rising edge, set state=IDLE, lrck_q=0, the shift register and counter to 0, data_l=data_r=0, valid_l=valid_r=0 and frame_err=0.
REQ-029 SHALL, on reset asserted mid-slot, abort the slot with no valid pulse; the first word after reset release follows REQ-015.

Configuration
REQ-030 SHALL, with macro I2S_RX_FRAME_ERR_EN defined, set frame_err to 1 in the cycle after any short-slot event (REQ-023) and hold it at 1 until reset.
REQ-031 SHALL, without I2S_RX_FRAME_ERR_EN, tie frame_err to constant 0 and synthesize no error logic; all other behaviour is identical.

Verification
REQ-032 SHALL cover: WORD_LENGTH=16, DATA_DELAY=1, 32-clk slots, left word 16'hA5C3 then right word 16'h0F0F -> valid_l in cycle E+17 with data_l=A5C3, then valid_r with data_r=0F0F; the first partial frame after reset produces no valid.
REQ-033 SHALL cover: DATA_DELAY=0, left word 16'h8001 with MSB driven in the edge cycle -> data_l=8001 and valid_l in cycle E+16.
REQ-034 SHALL cover: a right slot cut to 10 clks after a good right word 16'h1234 -> no valid_r, data_r stays 1234, frame_err=1 with the macro and 0 without, and the next full slot decodes correctly.
REQ-035 SHALL cover: reset=0 asserted at bit 7 of a left slot -> all outputs 0 the next cycle, no valid_l, and after release the second edge yields the first valid word.
REQ-036 SHALL cover: slot exactly 17 clks (DATA_DELAY=1) -> word accepted; slot of 16 clks -> short slot, edge coincides with last bit, no valid.
